// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: port address, default conditioner parameters and the pin-word type.
package gpio_pkg;
    localparam logic [31:0] GPIO_PORT_ADDRESS  = 32'h0000_8004;
    localparam int          DEF_WIDTH          = 32;
    localparam int          DEF_SYNC_STAGES    = 2;
    localparam int          DEF_PRESCALE       = 1000;
    localparam int          DEF_STABLE_SAMPLES = 4;

    typedef logic [DEF_WIDTH-1:0] pin_word_t;
endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for a word of asynchronous inputs; reusable for any async input.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_stage <= '0;
        else     r_stage <= {r_stage[SYNC_STAGES-2:0], i_async};
    end

    assign o_sync = r_stage[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: synchronizer, prescaled sample-and-agree debouncer, optional edge IRQ.
// Define GPIO_EDGE_IRQ_EN to build the edge detect / pending / irq logic.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PRESCALE       = DEF_PRESCALE,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    input  logic             db_bypass,
    output logic [WIDTH-1:0] clean_out,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] rise_pend,
    output logic [WIDTH-1:0] fall_pend,
    output logic             irq
);
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_clean_nxt;
    logic [WIDTH-1:0] r_clean;
    logic [PCW-1:0]   r_pcnt;
    logic             w_tick;

    gpio_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(pins_in),
        .o_sync (w_s)
    );

    // With PRESCALE=1 the 1-bit counter sits at 0, so the tick is permanent.
    assign w_tick = (r_pcnt == PCW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_pcnt <= '0;
        else if (w_tick) r_pcnt <= '0;
        else             r_pcnt <= r_pcnt + PCW'(1);
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        logic [STABLE_SAMPLES-1:0] r_hist;
        logic [STABLE_SAMPLES-1:0] w_hist_nxt;

        assign w_hist_nxt = {r_hist[STABLE_SAMPLES-2:0], w_s[g]};

        always_ff @(posedge clk or posedge rst) begin
            if (rst)         r_hist <= '0;
            else if (w_tick) r_hist <= w_hist_nxt;
        end

        // Decision looks at the history including the sample taken on this tick.
        always_comb begin
            w_clean_nxt[g] = r_clean[g];
            if (db_bypass)               w_clean_nxt[g] = w_s[g];
            else if (w_tick) begin
                if (&w_hist_nxt)         w_clean_nxt[g] = 1'b1;
                else if (~|w_hist_nxt)   w_clean_nxt[g] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_clean <= '0;
        else     r_clean <= w_clean_nxt;
    end

    assign clean_out = r_clean;

`ifdef GPIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise_pend;
    logic [WIDTH-1:0] r_fall_pend;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    assign w_rise = r_clean & ~r_prev;
    assign w_fall = ~r_clean & r_prev;

    // Set terms are ORed after the clear mask so a coincident edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= '0;
            r_rise_pend <= '0;
            r_fall_pend <= '0;
        end else begin
            r_prev      <= r_clean;
            r_rise_pend <= (r_rise_pend & ~irq_clr) | (w_rise & rise_en);
            r_fall_pend <= (r_fall_pend & ~irq_clr) | (w_fall & fall_en);
        end
    end

    assign rise_pend = r_rise_pend;
    assign fall_pend = r_fall_pend;
    assign irq       = |{r_rise_pend, r_fall_pend};
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{rise_en, fall_en, irq_clr};

    assign rise_pend = '0;
    assign fall_pend = '0;
    assign irq       = 1'b0;
`endif
endmodule
